// File: rtl/median_window_feeder.sv
// median_window_feeder: buffers one window of 8-bit pixels, then emits the median actor's
// header tokens followed by the buffered pixels. Option: MEDIAN_FEEDER_MO3_PIVOT_EN (median-of-three pivot).
module median_window_feeder #(
    parameter int unsigned WIN_MAX = 1024,
    parameter int unsigned AW      = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] in_cfg_data,
    input  logic        in_cfg_wr,
    output logic        in_cfg_full,
    input  logic [7:0]  in_px_data,
    input  logic        in_px_wr,
    output logic        in_px_full,
    output logic [10:0] out_buff_size_data,
    output logic        out_buff_size_wr,
    input  logic        out_buff_size_full,
    output logic [10:0] out_median_pos_data,
    output logic        out_median_pos_wr,
    input  logic        out_median_pos_full,
    output logic [7:0]  out_pivot_data,
    output logic        out_pivot_wr,
    input  logic        out_pivot_full,
    output logic [7:0]  out_second_median_value_data,
    output logic        out_second_median_value_wr,
    input  logic        out_second_median_value_full,
    output logic [7:0]  out_px_data,
    output logic        out_px_wr,
    input  logic        out_px_full
);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned SW = 11;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {IDLE, FILL, HDR, DRAIN} state_e;

    state_e state_q, state_d;

    logic [PW-1:0] n_q, n_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] first_q, first_d;
    logic [3:0]    done_q, done_d;
    logic          cfg_full_q, cfg_full_d;
    logic          px_full_q, px_full_d;
    logic [SW-1:0] bs_data_q, bs_data_d;
    logic          bs_wr_q, bs_wr_d;
    logic [SW-1:0] mp_data_q, mp_data_d;
    logic          mp_wr_q, mp_wr_d;
    logic [DW-1:0] pv_data_q, pv_data_d;
    logic          pv_wr_q, pv_wr_d;
    logic          sm_wr_q, sm_wr_d;
    logic          px_wr_q, px_wr_d;
    logic [DW-1:0] px_data_q;

    logic          cfg_acc_c;
    logic          px_acc_c;
    logic          rd_en_c;
    logic [PW-1:0] cfg_n_c;
    logic [PW-1:0] last_idx_c;
    logic [3:0]    hdr_go_c;
    logic          pivot_rdy_c;
    logic [DW-1:0] pivot_c;

    logic [DW-1:0] mem [WIN_MAX];

    assign cfg_n_c    = (in_cfg_data > SW'(WIN_MAX)) ? PW'(WIN_MAX) : PW'(in_cfg_data);
    assign last_idx_c = n_q - PW'(1);
    assign cfg_acc_c  = (state_q == IDLE) && cfg_full_q && in_cfg_wr;
    assign px_acc_c   = (state_q == FILL) && px_full_q && in_px_wr;
    assign rd_en_c    = (state_q == DRAIN) && out_px_full && (rd_ptr_q < n_q);

    // Header channels issue independently; each fires once per window
    assign hdr_go_c[0] = (state_q == HDR) && !done_q[0] && out_buff_size_full;
    assign hdr_go_c[1] = (state_q == HDR) && !done_q[1] && out_median_pos_full;
    assign hdr_go_c[2] = (state_q == HDR) && !done_q[2] && out_pivot_full && pivot_rdy_c;
    assign hdr_go_c[3] = (state_q == HDR) && !done_q[3] && out_second_median_value_full;
    assign done_d      = (state_q == HDR) ? (done_q | hdr_go_c) : 4'b0000;

`ifdef MEDIAN_FEEDER_MO3_PIVOT_EN
    logic [DW-1:0] mid_q, mid_d;
    logic [DW-1:0] last_q, last_d;
    logic [DW-1:0] med_q, med_d;
    logic          med_rdy_q, med_rdy_d;
    logic [PW-1:0] mid_idx_c;
    logic [DW-1:0] lo_c, hi_c, hi_min_c;

    assign mid_idx_c = last_idx_c >> 1;
    assign lo_c      = (first_q < mid_q) ? first_q : mid_q;
    assign hi_c      = (first_q < mid_q) ? mid_q : first_q;
    assign hi_min_c  = (hi_c < last_q) ? hi_c : last_q;
    assign med_d     = (lo_c > hi_min_c) ? lo_c : hi_min_c;
    assign med_rdy_d = (state_q == HDR);
    assign pivot_rdy_c = med_rdy_q;
    assign pivot_c     = med_q;

    always_comb begin
        mid_d  = mid_q;
        last_d = last_q;
        if (px_acc_c && (wr_ptr_q == mid_idx_c)) begin
            mid_d = in_px_data;
        end
        if (px_acc_c && (wr_ptr_q == last_idx_c)) begin
            last_d = in_px_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mid_q     <= '0;
            last_q    <= '0;
            med_q     <= '0;
            med_rdy_q <= 1'b0;
        end else begin
            mid_q     <= mid_d;
            last_q    <= last_d;
            med_q     <= med_d;
            med_rdy_q <= med_rdy_d;
        end
    end
`else
    assign pivot_rdy_c = 1'b1;
    assign pivot_c     = first_q;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cfg_acc_c && (cfg_n_c != '0)) state_d = FILL;
            FILL:    if (px_acc_c && (wr_ptr_q == last_idx_c)) state_d = HDR;
            HDR:     if (&done_d) state_d = DRAIN;
            DRAIN:   if (rd_en_c && (rd_ptr_q == last_idx_c)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_comb begin
        n_d        = n_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        first_d    = first_q;
        bs_data_d  = bs_data_q;
        mp_data_d  = mp_data_q;
        pv_data_d  = pv_data_q;
        bs_wr_d    = hdr_go_c[0];
        mp_wr_d    = hdr_go_c[1];
        pv_wr_d    = hdr_go_c[2];
        sm_wr_d    = hdr_go_c[3];
        px_wr_d    = rd_en_c;
        cfg_full_d = (state_q == IDLE) && (state_d == IDLE);
        px_full_d  = (state_d == FILL);

        if (cfg_acc_c && (cfg_n_c != '0)) begin
            n_d      = cfg_n_c;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        if (px_acc_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (wr_ptr_q == '0) begin
                first_d = in_px_data;
            end
        end
        if (rd_en_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (hdr_go_c[0]) begin
            bs_data_d = SW'(n_q);
        end
        if (hdr_go_c[1]) begin
            mp_data_d = SW'(last_idx_c >> 1);
        end
        if (hdr_go_c[2]) begin
            pv_data_d = pivot_c;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            first_q    <= '0;
            done_q     <= '0;
            cfg_full_q <= 1'b0;
            px_full_q  <= 1'b0;
            bs_data_q  <= '0;
            bs_wr_q    <= 1'b0;
            mp_data_q  <= '0;
            mp_wr_q    <= 1'b0;
            pv_data_q  <= '0;
            pv_wr_q    <= 1'b0;
            sm_wr_q    <= 1'b0;
            px_wr_q    <= 1'b0;
        end else begin
            n_q        <= n_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            first_q    <= first_d;
            done_q     <= done_d;
            cfg_full_q <= cfg_full_d;
            px_full_q  <= px_full_d;
            bs_data_q  <= bs_data_d;
            bs_wr_q    <= bs_wr_d;
            mp_data_q  <= mp_data_d;
            mp_wr_q    <= mp_wr_d;
            pv_data_q  <= pv_data_d;
            pv_wr_q    <= pv_wr_d;
            sm_wr_q    <= sm_wr_d;
            px_wr_q    <= px_wr_d;
        end
    end

    // Window buffer: write port from FILL, synchronous read port feeds out_px_data directly
    always_ff @(posedge clock) begin
        if (px_acc_c) begin
            mem[wr_ptr_q[AW-1:0]] <= in_px_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            px_data_q <= '0;
        end else if (rd_en_c) begin
            px_data_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign in_cfg_full                  = cfg_full_q;
    assign in_px_full                   = px_full_q;
    assign out_buff_size_data           = bs_data_q;
    assign out_buff_size_wr             = bs_wr_q;
    assign out_median_pos_data          = mp_data_q;
    assign out_median_pos_wr            = mp_wr_q;
    assign out_pivot_data               = pv_data_q;
    assign out_pivot_wr                 = pv_wr_q;
    assign out_second_median_value_data = '0;
    assign out_second_median_value_wr   = sm_wr_q;
    assign out_px_data                  = px_data_q;
    assign out_px_wr                    = px_wr_q;

endmodule
